// File: rtl/cordic_pkg.sv
// Shared types and Q2.22 constants for the CORDIC cosine accelerator front end.
package cordic_pkg;

  localparam logic [23:0] Q22_ONE     = 24'h400000;
  localparam logic [23:0] Q22_HALF_PI = 24'h6487ED;
  localparam logic [23:0] CORDIC_GAIN = 24'h26DD3B;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [22:0] frac;
  } float32_t;

  typedef logic signed [23:0] q22_t;

endpackage

// File: rtl/cordic_arg_prep_if.sv
// Operand/result handshake bundle between the upstream source, cordic_arg_prep and the accelerator wrapper.
interface cordic_arg_prep_if;
  import cordic_pkg::*;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] x_ft;
  logic        out_valid;
  logic        out_ready;
  q22_t        z_fx;
  logic        sat;
  logic        nan;
  logic        busy;

  modport master (
    output in_valid, x_ft, out_ready,
    input  in_ready, out_valid, z_fx, sat, nan, busy
  );

  modport slave (
    input  in_valid, x_ft, out_ready,
    output in_ready, out_valid, z_fx, sat, nan, busy
  );

endinterface

// File: rtl/fp_align_q22.sv
// Scales a float32 mantissa by 2^(exp-135), i.e. x/128 in Q2.22, and flags magnitudes too large to represent.
module fp_align_q22 (
  input  logic                sign,
  input  logic [7:0]          exp,
  input  logic [23:0]         mant24,
  output logic signed [27:0]  a,
  output logic                sat_pre
);

  logic [27:0] m;
  logic [7:0]  rsh;

  always_comb begin
    m       = '0;
    sat_pre = 1'b0;
    rsh     = 8'd135 - exp;
    if (exp >= 8'd138) begin
      sat_pre = 1'b1;
    end else if (exp >= 8'd135) begin
      m = {4'b0000, mant24} << (exp - 8'd135);
    end else if (rsh < 8'd24) begin
      m = {4'b0000, mant24} >> rsh;
    end
    a = sign ? -$signed(m) : $signed(m);
  end

endmodule

// File: rtl/cordic_arg_prep.sv
// Three-stage valid/ready pipeline turning float32 x into the clamped CORDIC angle z = x/128 - OFFSET (Q2.22).
module cordic_arg_prep
  import cordic_pkg::*;
#(
  parameter logic [23:0] OFFSET  = Q22_ONE,
  parameter logic [23:0] Z_LIMIT = Q22_HALF_PI
) (
  input logic              clk,
  input logic              reset,
  input logic              clk_en,
  cordic_arg_prep_if.slave bus
);

  localparam logic signed [27:0] OFFSET_X = {{4{OFFSET[23]}}, OFFSET};
  localparam logic signed [27:0] LIM_P    = {4'b0000, Z_LIMIT};
  localparam logic signed [27:0] LIM_N    = -LIM_P;

  float32_t xf;
  logic v1, v2, v3;
  logic load1, load2, load3;

  logic        s1_sign, s1_nan;
  logic [7:0]  s1_exp;
  logic [23:0] s1_mant;

  logic signed [27:0] al_a;
  logic               al_sat;

  logic               s2_sign, s2_nan, s2_sat_pre;
  logic signed [27:0] s2_a;

  logic signed [27:0] d;
  q22_t               z_nx;
  logic               sat_nx;

  q22_t z_q;
  logic sat_q, nan_q;

  assign xf = bus.x_ft;

  // A stage may load when empty or when its contents move on this cycle.
  assign load3 = clk_en & (~v3 | bus.out_ready);
  assign load2 = clk_en & (~v2 | load3);
  assign load1 = clk_en & (~v1 | load2);

  assign bus.in_ready  = load1;
  assign bus.out_valid = v3;
  assign bus.z_fx      = z_q;
  assign bus.sat       = sat_q;
  assign bus.nan       = nan_q;
  assign bus.busy      = v1 | v2 | v3;

  // S1: unpack; zero/subnormal operands collapse to +0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1      <= 1'b0;
      s1_sign <= 1'b0;
      s1_nan  <= 1'b0;
      s1_exp  <= '0;
      s1_mant <= '0;
    end else if (load1) begin
      v1 <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sign <= xf.sign & (xf.exp != 8'h00);
        s1_exp  <= xf.exp;
        s1_mant <= (xf.exp == 8'h00) ? '0 : {1'b1, xf.frac};
        s1_nan  <= (xf.exp == 8'hFF) && (xf.frac != '0);
      end
    end
  end

  fp_align_q22 u_align (
    .sign    (s1_sign),
    .exp     (s1_exp),
    .mant24  (s1_mant),
    .a       (al_a),
    .sat_pre (al_sat)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v2         <= 1'b0;
      s2_a       <= '0;
      s2_sign    <= 1'b0;
      s2_nan     <= 1'b0;
      s2_sat_pre <= 1'b0;
    end else if (load2) begin
      v2 <= v1;
      if (v1) begin
        s2_a       <= al_a;
        s2_sign    <= s1_sign;
        s2_nan     <= s1_nan;
        s2_sat_pre <= al_sat;
      end
    end
  end

  // S3: offset and clamp; NaN takes priority over any saturation.
  always_comb begin
    d      = s2_a - OFFSET_X;
    z_nx   = d[23:0];
    sat_nx = 1'b0;
    if (s2_nan) begin
      z_nx = '0;
    end else if (s2_sat_pre) begin
      z_nx   = s2_sign ? LIM_N[23:0] : Z_LIMIT;
      sat_nx = 1'b1;
    end else if (d > LIM_P) begin
      z_nx   = Z_LIMIT;
      sat_nx = 1'b1;
    end else if (d < LIM_N) begin
      z_nx   = LIM_N[23:0];
      sat_nx = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v3    <= 1'b0;
      z_q   <= '0;
      sat_q <= 1'b0;
      nan_q <= 1'b0;
    end else if (load3) begin
      v3 <= v2;
      if (v2) begin
        z_q   <= z_nx;
        sat_q <= sat_nx;
        nan_q <= s2_nan;
      end
    end
  end

endmodule
